// File: rtl/mem_share_arbiter_pkg.sv
// rtl/mem_share_arbiter_pkg.sv - shared types and helpers for the memory-share arbiter
package mem_share_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ARB    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Exchanges the lower and upper halves of the low w bits of d (w even, w <= 64).
  function automatic logic [63:0] half_swap(input logic [63:0] d, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w / 2; i++) begin
      r[i + w / 2] = d[i];
      r[i]         = d[i + w / 2];
    end
    return r;
  endfunction

  // True when addr lies in the upper half of a 2**psize deep memory.
  function automatic logic in_upper_half(input logic [31:0] addr, input int psize);
    logic [31:0] half;
    half = (32'd1 << psize) >> 1;
    return (addr >= half);
  endfunction

endpackage

// File: rtl/mem_share_arbiter_rr_pick.sv
// rtl/mem_share_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  int j;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_share_arbiter.sv
// rtl/mem_share_arbiter.sv - round-robin arbiter sharing one register memory among NREQ requesters
module mem_share_arbiter
  import mem_share_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int PSIZE    = 2,
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 4,
  parameter int UNSWAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*PSIZE-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [PSIZE-1:0]        mem_wr_addr,
  output logic [PSIZE-1:0]        mem_rd_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(LOCK_MAX + 1);

  state_t          state, state_n;
  logic [IDXW-1:0] rr_ptr, rr_ptr_n;
  logic [IDXW-1:0] owner, owner_n;
  logic [CNTW-1:0] lock_cnt, lock_cnt_n;
  logic [NREQ-1:0] rsp_valid_n;

  logic [NREQ-1:0] pick_grant;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] gnt_idx;
  logic            xfer;

  logic             sel_wr;
  logic [PSIZE-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      rsp_valid <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      lock_cnt  <= lock_cnt_n;
      rsp_valid <= rsp_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    lock_cnt_n = lock_cnt;
    case (state)
      ST_INIT: state_n = ST_ARB;
      ST_ARB: begin
        if (xfer) begin
          rr_ptr_n = next_idx(gnt_idx);
          // A single-grant budget makes a lock meaningless, so stay in ARB.
          if (req_lock[gnt_idx] && LOCK_MAX > 1) begin
            state_n    = ST_LOCKED;
            owner_n    = gnt_idx;
            lock_cnt_n = CNTW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!req_valid[owner]) begin
          state_n    = ST_ARB;
          lock_cnt_n = '0;
        end else begin
          rr_ptr_n = next_idx(owner);
          if (!req_lock[owner] || lock_cnt == CNTW'(LOCK_MAX - 1)) begin
            state_n    = ST_ARB;
            lock_cnt_n = '0;
          end else begin
            lock_cnt_n = lock_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_comb begin
    grant   = '0;
    gnt_idx = pick_idx;
    xfer    = 1'b0;
    case (state)
      ST_ARB: begin
        grant = pick_grant;
        xfer  = pick_any;
      end
      ST_LOCKED: begin
        gnt_idx = owner;
        if (req_valid[owner]) begin
          grant[owner] = 1'b1;
          xfer         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = grant;

  assign sel_wr    = req_wr[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx) * PSIZE +: PSIZE];
  assign sel_wdata = req_wdata[int'(gnt_idx) * WIDTH +: WIDTH];

  // Upper-half writes are pre-swapped so the memory's own read swap undoes them.
  always_comb begin
    mem_wr      = xfer & sel_wr;
    mem_rd      = xfer & ~sel_wr;
    mem_wr_addr = mem_wr ? sel_addr : '0;
    mem_rd_addr = mem_rd ? sel_addr : '0;
    mem_wdata   = '0;
    if (mem_wr) begin
      if (UNSWAP != 0 && in_upper_half(32'(sel_addr), PSIZE))
        mem_wdata = WIDTH'(half_swap(64'(sel_wdata), WIDTH));
      else
        mem_wdata = sel_wdata;
    end
    rsp_valid_n = mem_rd ? grant : '0;
  end

  assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// tb/tb_mem_share_arbiter.sv - scoreboard bench for mem_share_arbiter
module tb_mem_share_arbiter;

  localparam int WIDTH = 2;
  localparam int PSIZE = 2;
  localparam int NREQ  = 2;
  localparam int DEPTH = 2 ** PSIZE;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready, req_wr, req_lock;
  logic [NREQ*PSIZE-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  mem_wr, mem_rd;
  logic [PSIZE-1:0]      mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  mem_share_arbiter #(
    .WIDTH(WIDTH), .PSIZE(PSIZE), .NREQ(NREQ), .LOCK_MAX(4), .UNSWAP(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Register memory with upper-half read swap, cleared by rst_n.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr) mem[mem_wr_addr] <= mem_wdata;
      if (mem_rd) begin
        if (mem_rd_addr >= PSIZE'(DEPTH / 2))
          mem_rdata <= {mem[mem_rd_addr][0], mem[mem_rd_addr][1]};
        else
          mem_rdata <= mem[mem_rd_addr];
      end
    end
  end

  typedef struct {
    int               cyc;
    int               idx;
    bit               wr;
    logic [PSIZE-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } xfer_t;

  typedef struct {
    int               cyc;
    int               idx;
    logic [WIDTH-1:0] data;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  xfer_t ex;
  rsp_t  er;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_rd_excl", 32'(mem_wr & mem_rd), 32'd0);
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("ready_idle", 32'(req_ready & ~req_valid), 32'd0);
      if (xq.size() > 0 && xq[0].cyc == cyc) begin
        ex = xq.pop_front();
        chk("xfer_grant", 32'(req_ready & req_valid), 32'(1) << ex.idx);
        chk("xfer_mem_wr", 32'(mem_wr), 32'(ex.wr));
        chk("xfer_mem_rd", 32'(mem_rd), 32'(!ex.wr));
        chk("xfer_addr", 32'(ex.wr ? mem_wr_addr : mem_rd_addr), 32'(ex.addr));
        if (ex.wr) chk("xfer_wdata", 32'(mem_wdata), 32'(ex.wdata));
      end else begin
        chk("xfer_unexpected", 32'(req_ready & req_valid), 32'd0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        er = rq.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << er.idx);
        chk("rsp_data", 32'(rsp_data), 32'(er.data));
      end else begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
    end
  end

  // Drives one cycle of requests; g is the hand-computed granted requester (-1 = none).
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                      input logic [3:0] a, input logic [3:0] d, input int g,
                      input logic [1:0] ewd, input bit do_rsp, input logic [1:0] erd);
    xfer_t x;
    rsp_t  r;
    req_valid = v;
    req_wr    = w;
    req_lock  = lk;
    req_addr  = a;
    req_wdata = d;
    if (g >= 0) begin
      x.cyc   = cyc;
      x.idx   = g;
      x.wr    = w[g];
      x.addr  = a[g*2 +: 2];
      x.wdata = ewd;
      xq.push_back(x);
      if (!w[g] && do_rsp) begin
        r.cyc  = cyc + 1;
        r.idx  = g;
        r.data = erd;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    mon_en    = 1'b1;
    req_valid = 2'b01;
    req_wr    = 2'b01;
    req_addr  = {2'd0, 2'd3};
    req_wdata = {2'b00, 2'b10};
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_mem_wr", 32'(mem_wr), 32'd0);
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;

    // Swap restore: upper-half address is pre-swapped, lower-half passes through.
    step(2'b01, 2'b01, 2'b00, {2'd0, 2'd3}, {2'b00, 2'b10}, 0, 2'b01, 1'b0, 2'b00);
    step(2'b01, 2'b00, 2'b00, {2'd0, 2'd3}, 4'h0,           0, 2'b00, 1'b1, 2'b10);
    step(2'b01, 2'b01, 2'b00, {2'd0, 2'd1}, {2'b00, 2'b10}, 0, 2'b10, 1'b0, 2'b00);
    step(2'b01, 2'b00, 2'b00, {2'd0, 2'd1}, 4'h0,           0, 2'b00, 1'b1, 2'b10);

    // Round robin with both requesters reading addr 1; pointer sits at 1 here.
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b00, 2'b00, {2'd1, 2'd1}, 4'h0, (i % 2 == 0) ? 1 : 0, 2'b00, 1'b1, 2'b10);

    // Lock limit: req1 first (pointer at 1), then four locked req0 grants, then req1.
    begin
      int g_seq[6] = '{1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++)
        step(2'b11, 2'b00, 2'b01, {2'd0, 2'd1}, 4'h0, g_seq[i], 2'b00, 1'b1,
             (g_seq[i] == 0) ? 2'b10 : 2'b00);
    end

    // Write then read of the same address on consecutive cycles sees new data.
    step(2'b01, 2'b01, 2'b00, {2'd0, 2'd0}, {2'b00, 2'b11}, 0, 2'b11, 1'b0, 2'b00);
    step(2'b10, 2'b00, 2'b00, {2'd0, 2'd0}, 4'h0,           1, 2'b00, 1'b1, 2'b11);

    // Locked read transfers while reset is sampled at the end of the cycle.
    rst_n = 1'b0;
    step(2'b01, 2'b00, 2'b01, {2'd0, 2'd1}, 4'h0, 0, 2'b00, 1'b0, 2'b00);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_lock  = 2'b00;
    req_addr  = {2'd3, 2'd1};
    @(negedge clk);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_init_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    step(2'b11, 2'b00, 2'b00, {2'd3, 2'd1}, 4'h0, 0, 2'b00, 1'b1, 2'b00);
    step(2'b11, 2'b00, 2'b00, {2'd3, 2'd1}, 4'h0, 1, 2'b00, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++)
      step(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, -1, 2'b00, 1'b0, 2'b00);

    chk("xfer_queue_drained", 32'(xq.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_share_arbiter.md
Name: mem_share_arbiter

Overview:
- Shares one single-port-write/single-port-read register memory between NREQ requesters. Each requester issues read or write requests over a valid/ready handshake.
- Round-robin arbitration, with an optional bounded lock for back-to-back bursts.
- Drives the memory's in_wr/in_rd/address/data controls, never asserting write and read in the same cycle.
- Returns read data one cycle after issue and optionally pre-swaps write data so upper-half addresses read back in original order.

Parameters:
- WIDTH, 2, data word width; must be even.
- PSIZE, 2, address width; DEPTH = 2**PSIZE.
- NREQ, 2, number of requesters (2..8).
- LOCK_MAX, 4, maximum consecutive grants to one locked requester before a forced rotate.
- UNSWAP, 1, 1 = pre-swap write data halves for addresses >= DEPTH/2; 0 = pass-through.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept (one-hot or zero).
- req_wr  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  request to keep the grant on the next cycle.
- req_addr  in  NREQ*PSIZE  packed addresses, requester i at [i*PSIZE +: PSIZE].
- req_wdata  in  NREQ*WIDTH  packed write data.
- rsp_valid  out  NREQ  one-hot read-response strobe.
- rsp_data  out  WIDTH  read data, qualified by rsp_valid.
- mem_wr  out  1  memory write enable.
- mem_rd  out  1  memory read enable.
- mem_wr_addr  out  PSIZE  memory write address.
- mem_rd_addr  out  PSIZE  memory read address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory registered read output.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rr_ptr=0, state=INIT, lock_cnt=0, rsp_valid=0.
  - req_ready=0, mem_wr=0, mem_rd=0; addresses and data are 0.
  - The memory itself is cleared by the same rst_n.
- States:
  - INIT: one cycle after reset release, req_ready=0. Goes to ARB unconditionally.
  - ARB: normal arbitration.
  - LOCKED: the current owner holds the grant.
- ARB arbitration:
  - Grant goes to the first valid requester at or after rr_ptr, cyclically. This is combinational.
  - req_ready[g]=1 only for that requester.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - On transfer: rr_ptr <= g+1 mod NREQ.
  - If req_lock[g]=1: go to LOCKED, owner <= g, lock_cnt <= 1.
- LOCKED:
  - The owner is granted whenever req_valid[owner]=1; other requesters get ready=0.
  - Each transfer increments lock_cnt.
  - Exit to ARB when any of these holds: req_lock[owner]=0 at a transfer; req_valid[owner]=0 for a cycle; lock_cnt reaches LOCK_MAX.
  - Exit through the lock_cnt limit forces rr_ptr past the owner.
- Memory drive: combinational from the granted request in the transfer cycle.
  - Write: mem_wr=1, mem_rd=0.
  - Read: mem_rd=1, mem_wr=0.
  - No transfer: both 0. Write and read are never high together.
- Write data rule: if UNSWAP=1 and addr >= DEPTH/2, mem_wdata = {wdata[WIDTH/2-1:0], wdata[WIDTH-1:WIDTH/2]}. Otherwise mem_wdata = wdata. The memory's own upper-half swap then restores the original order.
- Read latency: a read transferred in cycle T gives rsp_valid[g]=1 in T+1, with rsp_data=mem_rdata. rsp_valid is registered and rsp_data is a pass-through.
- Pipelining: a new transfer is allowed in T+1. Back-to-back reads give one response per cycle.
- Hazards:
  - Write in T then read of the same address in T+1 returns the new data.
  - Read in T then write in T+1 returns the old data.
- Reset mid-operation: a pending rsp_valid is dropped (0 after the reset edge), the lock is released and rr_ptr returns to 0.
- Requester rules: req_* must be held stable while valid & !ready. An idle request (valid=0) never gets ready.

Decomposition:
- Package mem_share_pkg: state enum (INIT, ARB, LOCKED), a half-swap function parameterised by WIDTH, and a helper for the DEPTH/2 threshold.
- Sub-module rr_pick: combinational round-robin priority picker (NREQ valids + pointer -> one-hot grant + index).
- Lock counter, FSM and datapath mux live in the top module.

Test Plan:
- Reset then idle (defaults WIDTH=2, PSIZE=2, NREQ=2): hold rst_n=0 for 2 cycles, then release → req_ready=0 in the INIT cycle; mem_wr=mem_rd=0 and rsp_valid=0 throughout.
- Round robin: req0 and req1 both valid reads of addr 1 continuously → grants alternate 0,1,0,1; rsp_valid alternates 01,10,… one cycle later; never two ready bits high.
- Swap restore, UNSWAP=1:
  - req0 writes 2'b10 to addr 3 → mem_wdata=2'b01.
  - req0 then reads addr 3 → rsp_data=2'b10.
  - Same sequence to addr 1 → mem_wdata=2'b10.
- Lock limit, LOCK_MAX=4: req0 valid and locked continuously, req1 valid → req0 gets exactly 4 consecutive grants, then req1 is granted in the next cycle.
- Mixed hazard: req0 writes 2'b11 to addr 0 in T, req1 reads addr 0 in T+1 → rsp_valid[1]=1 in T+2 with rsp_data=2'b11; mem_wr and mem_rd are never both 1.
- Reset mid-read: read transfers in T, rst_n=0 at the T+1 edge → rsp_valid=0 after that edge, lock cleared, rr_ptr=0, then INIT.
